// File: rtl/ps2_scan_sequencer.sv
// rtl/ps2_scan_sequencer.sv - PS/2 Set-2 scan code sequencer with FWFT event FIFO
module ps2_scan_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scan_valid,
  input  logic [7:0]                  scan_code,
  input  logic                        event_ready,
  input  logic                        err_clear,
  output logic                        event_valid,
  output logic [7:0]                  event_code,
  output logic                        event_break,
  output logic                        event_ext,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        proto_err,
  output logic                        rx_err,
  output logic                        overflow,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_TERM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;
  localparam logic [7:0] CODE_ERR0  = 8'h00;
  localparam logic [7:0] CODE_ERR1  = 8'hFF;

  // Pause is E1 followed by seven more bytes that carry no extra meaning.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_SKIP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [2:0]      skip_cnt;
  logic [2:0]      skip_cnt_nx;
  logic [TW-1:0]   timer;
  logic            timeout;
  logic            is_err_code;

  // Event entry layout: {code[7:0], break, ext}
  logic            push;
  logic [9:0]      push_data;
  logic            set_rx;
  logic            set_proto;

  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            push_ok;
  logic            drop;
  logic [9:0]      head;

  assign is_err_code = (scan_code == CODE_ERR0) || (scan_code == CODE_ERR1);

  // A byte arriving on the terminal count wins over the timeout.
  assign timeout = !scan_valid && (state != S_IDLE) && (timer == TIMER_TERM);

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_cnt_nx;
    end
  end

  // Prefix decoding: next state, event push and error detection.
  always_comb begin
    state_nx    = state;
    skip_cnt_nx = skip_cnt;
    push        = 1'b0;
    push_data   = '0;
    set_rx      = 1'b0;
    set_proto   = 1'b0;

    if (scan_valid) begin
      if (is_err_code) begin
        set_rx      = 1'b1;
        state_nx    = S_IDLE;
        skip_cnt_nx = '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (scan_code == CODE_EXT) begin
              state_nx = S_E0;
            end else if (scan_code == CODE_BRK) begin
              state_nx = S_F0;
            end else if (scan_code == CODE_PAUSE) begin
              state_nx    = S_SKIP;
              skip_cnt_nx = PAUSE_TAIL;
            end else begin
              push      = 1'b1;
              push_data = {scan_code, 2'b00};
            end
          end
          S_E0: begin
            if (scan_code == CODE_BRK) begin
              state_nx = S_E0F0;
            end else if (scan_code == CODE_EXT) begin
              state_nx = S_E0;
            end else begin
              push      = 1'b1;
              push_data = {scan_code, 2'b01};
              state_nx  = S_IDLE;
            end
          end
          S_F0: begin
            push      = 1'b1;
            push_data = {scan_code, 2'b10};
            state_nx  = S_IDLE;
          end
          S_E0F0: begin
            push      = 1'b1;
            push_data = {scan_code, 2'b11};
            state_nx  = S_IDLE;
          end
          S_SKIP: begin
            if (skip_cnt == 3'd1) begin
              push        = 1'b1;
              push_data   = {CODE_PAUSE, 2'b01};
              state_nx    = S_IDLE;
              skip_cnt_nx = '0;
            end else begin
              skip_cnt_nx = skip_cnt - 3'd1;
            end
          end
          default: begin
            state_nx    = S_IDLE;
            skip_cnt_nx = '0;
          end
        endcase
      end
    end else if (timeout) begin
      set_proto   = 1'b1;
      state_nx    = S_IDLE;
      skip_cnt_nx = '0;
    end
  end

  // Inter-byte timer: restarts on every byte, idles at zero outside a sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (scan_valid || (state == S_IDLE) || timeout) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign pop        = event_ready && !fifo_empty;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  // Event storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
      rx_err    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (err_clear) begin
        proto_err <= 1'b0;
        rx_err    <= 1'b0;
        overflow  <= 1'b0;
      end
      if (set_proto) begin
        proto_err <= 1'b1;
      end
      if (set_rx) begin
        rx_err <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Head is masked while empty so stale storage never reaches the consumer.
  assign head        = fifo_empty ? 10'd0 : mem[rd_ptr];
  assign event_valid = !fifo_empty;
  assign event_code  = head[9:2];
  assign event_break = head[1];
  assign event_ext   = head[0];
  assign fifo_count  = count;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb/tb_ps2_scan_sequencer.sv - self-checking bench for ps2_scan_sequencer
module tb_ps2_scan_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       clk;
  logic       reset;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       event_ready;
  logic       err_clear;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_break;
  logic       event_ext;
  logic [2:0] fifo_count;
  logic       proto_err;
  logic       rx_err;
  logic       overflow;
  logic       busy;

  ps2_scan_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_valid  (scan_valid),
    .scan_code   (scan_code),
    .event_ready (event_ready),
    .err_clear   (err_clear),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_break (event_break),
    .event_ext   (event_ext),
    .fifo_count  (fifo_count),
    .proto_err   (proto_err),
    .rx_err      (rx_err),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pending bytes of the sequence in progress, queued events, flags.
  logic [7:0] seq[$];
  logic [9:0] mq[$];
  int         idle_cnt = 0;
  logic       m_proto  = 1'b0;
  logic       m_rx     = 1'b0;
  logic       m_ovf    = 1'b0;
  logic       armed    = 1'b0;

  wire [17:0] dut_vec  = {event_valid, event_code, event_break, event_ext,
                          fifo_count, proto_err, rx_err, overflow, busy};
  wire [10:0] dut_head = {event_valid, event_code, event_break, event_ext};
  wire [3:0]  dut_flag = {proto_err, rx_err, overflow, busy};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Interpret one byte from the accumulated sequence rather than a state label.
  task automatic model_byte(input logic [7:0] b, output logic have,
                            output logic [9:0] ev, output logic rxe);
    logic has_e0;
    logic has_f0;
    have   = 1'b0;
    ev     = '0;
    rxe    = 1'b0;
    has_e0 = 1'b0;
    has_f0 = 1'b0;
    foreach (seq[i]) begin
      if (seq[i] == 8'hE0) has_e0 = 1'b1;
      if (seq[i] == 8'hF0) has_f0 = 1'b1;
    end
    if (b == 8'h00 || b == 8'hFF) begin
      rxe = 1'b1;
      seq.delete();
    end else if (seq.size() > 0 && seq[0] == 8'hE1) begin
      seq.push_back(b);
      if (seq.size() == 8) begin
        have = 1'b1;
        ev   = {8'hE1, 2'b01};
        seq.delete();
      end
    end else if (b == 8'hE1 && seq.size() == 0) begin
      seq.push_back(b);
    end else if ((b == 8'hE0 || b == 8'hF0) && !has_f0) begin
      seq.push_back(b);
    end else begin
      have = 1'b1;
      ev   = {b, has_f0, has_e0};
      seq.delete();
    end
  endtask

  // Advance one clock: update the model with the sampled inputs, then compare.
  task automatic step();
    logic       have;
    logic       rxe;
    logic       pop;
    logic       setp;
    logic       seto;
    logic [9:0] ev;
    logic [9:0] hd;
    logic [17:0] exp_vec;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      seq.delete();
      idle_cnt = 0;
      m_proto  = 1'b0;
      m_rx     = 1'b0;
      m_ovf    = 1'b0;
      armed    = 1'b1;
    end else begin
      have = 1'b0;
      rxe  = 1'b0;
      ev   = '0;
      setp = 1'b0;
      seto = 1'b0;
      pop  = event_ready && (mq.size() > 0);
      if (scan_valid) begin
        idle_cnt = 0;
        model_byte(scan_code, have, ev, rxe);
      end else if (seq.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == TIMEOUT) begin
          seq.delete();
          setp     = 1'b1;
          idle_cnt = 0;
        end
      end
      if (pop) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < DEPTH) mq.push_back(ev);
        else seto = 1'b1;
      end
      if (err_clear) begin
        m_proto = 1'b0;
        m_rx    = 1'b0;
        m_ovf   = 1'b0;
      end
      if (setp) m_proto = 1'b1;
      if (rxe)  m_rx    = 1'b1;
      if (seto) m_ovf   = 1'b1;
    end
    #2;
    if (armed) begin
      hd      = (mq.size() > 0) ? mq[0] : 10'd0;
      exp_vec = {mq.size() > 0, hd, 3'(mq.size()), m_proto, m_rx, m_ovf, seq.size() > 0};
      chk("cycle_outputs", 32'(dut_vec), 32'(exp_vec));
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code  = b;
    step();
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pop_one();
    event_ready = 1'b1;
    step();
    event_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] pause_tail [7];
    logic [7:0] fill [4];
    pause_tail = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    fill       = '{8'h15, 8'h1D, 8'h24, 8'h2D};

    reset       = 1'b1;
    scan_valid  = 1'b0;
    scan_code   = 8'h00;
    event_ready = 1'b0;
    err_clear   = 1'b0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    chk("reset_outputs", 32'(dut_vec), 32'h0);

    // Basic make / break / extended decoding with a ready consumer.
    event_ready = 1'b1;
    send(8'h1C);
    chk("make_1c", 32'(dut_head), {21'd0, 1'b1, 8'h1C, 2'b00});
    idle(10);
    send(8'hF0);
    idle(9);
    send(8'h1C);
    chk("break_1c", 32'(dut_head), {21'd0, 1'b1, 8'h1C, 2'b10});
    idle(10);
    send(8'hE0);
    idle(9);
    send(8'h75);
    chk("ext_make_75", 32'(dut_head), {21'd0, 1'b1, 8'h75, 2'b01});
    idle(10);
    send(8'hE0);
    idle(9);
    send(8'hF0);
    idle(9);
    send(8'h75);
    chk("ext_break_75", 32'(dut_head), {21'd0, 1'b1, 8'h75, 2'b11});
    idle(10);
    chk("t1_flags_quiet", 32'(dut_flag), 32'h0);

    // Back-to-back strobes on consecutive cycles.
    event_ready = 1'b0;
    scan_valid  = 1'b1;
    scan_code   = 8'hE0; step();
    scan_code   = 8'h74; step();
    scan_code   = 8'h1C; step();
    scan_code   = 8'hF0; step();
    scan_code   = 8'h1C; step();
    scan_valid  = 1'b0;
    chk("burst_count", 32'(fifo_count), 32'd3);
    chk("burst_head", 32'(dut_head), {21'd0, 1'b1, 8'h74, 2'b01});
    event_ready = 1'b1;
    idle(4);
    event_ready = 1'b0;
    chk("burst_drained", 32'(fifo_count), 32'd0);

    // Pause sequence yields a single event.
    send(8'hE1);
    chk("pause_busy_first", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) send(pause_tail[i]);
    chk("pause_busy_seventh", 32'(busy), 32'd1);
    chk("pause_no_early_event", 32'(fifo_count), 32'd0);
    send(pause_tail[6]);
    chk("pause_busy_done", 32'(busy), 32'd0);
    chk("pause_event", 32'(dut_head), {21'd0, 1'b1, 8'hE1, 2'b01});
    chk("pause_count", 32'(fifo_count), 32'd1);
    pop_one();

    // Stalled sequence times out on the 16th edge after the prefix.
    send(8'hF0);
    idle(15);
    chk("timeout_busy_before", 32'(dut_flag), 32'b0001);
    idle(1);
    chk("timeout_fired", 32'(dut_flag), 32'b1000);
    idle(3);
    send(8'h1C);
    chk("after_timeout_make", 32'(dut_head), {21'd0, 1'b1, 8'h1C, 2'b00});
    pop_one();
    clear_errs();
    chk("proto_cleared", 32'(proto_err), 32'd0);

    // Overflow with a stalled consumer, then in-order drain.
    for (int i = 0; i < 4; i++) send(fill[i]);
    chk("fill_count", 32'(fifo_count), 32'd4);
    send(8'h2C);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(dut_head), {21'd0, 1'b1, fill[i], 2'b00});
      pop_one();
    end
    chk("drained_empty", 32'(dut_head), 32'h0);
    clear_errs();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO: push and pop in one cycle both succeed.
    for (int i = 0; i < 4; i++) send(fill[i]);
    scan_valid  = 1'b1;
    scan_code   = 8'h35;
    event_ready = 1'b1;
    step();
    scan_valid  = 1'b0;
    event_ready = 1'b0;
    chk("full_pushpop_count", 32'(fifo_count), 32'd4);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    chk("full_pushpop_head", 32'(dut_head), {21'd0, 1'b1, 8'h1D, 2'b00});
    event_ready = 1'b1;
    idle(6);
    event_ready = 1'b0;
    chk("pop_empty_ignored", 32'(fifo_count), 32'd0);

    // Receiver error codes in IDLE and mid-sequence.
    send(8'hFF);
    chk("rx_err_idle", 32'(dut_flag), 32'b0100);
    chk("rx_err_no_event", 32'(fifo_count), 32'd0);
    clear_errs();
    chk("flags_cleared", 32'(dut_flag), 32'h0);
    send(8'hE0);
    send(8'h00);
    chk("rx_err_in_seq", 32'(dut_flag), 32'b0100);
    err_clear = 1'b1;
    send(8'hFF);
    err_clear = 1'b0;
    chk("set_wins_over_clear", 32'(rx_err), 32'd1);
    clear_errs();

    // Reset mid-sequence abandons the prefix.
    send(8'hE0);
    chk("mid_seq_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_seq_reset", 32'(dut_vec), 32'h0);
    send(8'h1C);
    chk("post_reset_make", 32'(dut_head), {21'd0, 1'b1, 8'h1C, 2'b00});
    pop_one();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scan_sequencer.md
# ps2_scan_sequencer

Controller between the PS/2 byte receiver and any keyboard consumer. It takes the 8-bit scan codes from the receive shift register, one per single-cycle strobe, and runs the Set-2 prefix state machine for make, break (0xF0), extended (0xE0) and Pause (0xE1) sequences. Each completed key event goes into a small first-word-fall-through FIFO with a valid/ready handshake. It also detects stalled sequences, receiver error codes and FIFO overflow, and reports them through sticky flags.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of one sequence (2 ms at 50 MHz)
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high; clears all state on the rising clk edge where it is high
- scan_valid  in  1  one-cycle strobe, already synchronised to clk; scan_code is valid while it is high
- scan_code  in  8  received byte
- event_ready  in  1  consumer accepts the head event when event_valid && event_ready
- err_clear  in  1  clears proto_err, rx_err and overflow
- event_valid  out  1  FIFO non-empty
- event_code  out  8  key code of the head event
- event_break  out  1  head event is a release
- event_ext  out  1  head event carried the 0xE0 prefix
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- proto_err  out  1  sticky: a sequence timed out
- rx_err  out  1  sticky: byte 0x00 or 0xFF received
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- busy  out  1  sequencer not in IDLE

## Operation
- States: IDLE, E0, F0, E0F0, SKIP.
- IDLE:
  - 0xE0 → E0.
  - 0xF0 → F0.
  - 0xE1 → SKIP, with skip_cnt=7.
  - 0x00 or 0xFF → set rx_err, stay in IDLE, no event.
  - Any other byte → push {code, break=0, ext=0}, stay in IDLE.
- E0:
  - 0xF0 → E0F0.
  - 0xE0 → stay in E0.
  - Any other byte → push {code, 0, 1}, go to IDLE.
- F0: any byte → push {code, 1, 0}, go to IDLE.
- E0F0: any byte → push {code, 1, 1}, go to IDLE.
- SKIP:
  - Each byte decrements skip_cnt.
  - When the byte arrives with skip_cnt==1, push {0xE1, 0, 1} (Pause) and go to IDLE.
- Error codes in a non-IDLE state: 0x00/0xFF set rx_err, return to IDLE, no event.
- Timeout:
  - timer clears on every scan_valid and runs while the state is not IDLE.
  - When timer reaches TIMEOUT_CYCLES-1 with no scan_valid in that cycle: go to IDLE, set proto_err, no event.
  - A scan_valid in the same cycle as the terminal count is accepted; no timeout occurs.
- FIFO push and pop:
  - Push while full (and no pop in that cycle) drops the event and sets overflow.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Pop while empty is ignored.
  - Push and event_ready in the same cycle while empty: push only.
- Sticky flags: err_clear clears all three. If a set condition occurs in the same cycle as err_clear, the set wins.
- Reset values: every output is 0 and state is IDLE. FIFO pointers, timer and skip_cnt are 0.
- Reset in mid-sequence abandons the sequence; the next byte is decoded from IDLE.

## Timing
- scan_valid at edge n → event visible on event_valid/event_code after edge n (usable at cycle n+1). Latency is 1 cycle.
- Head outputs are driven combinationally from FIFO storage. They are stable while event_valid=1 and event_ready=0.
- A pop at edge m exposes the next entry, or deasserts event_valid, from cycle m+1.
- One byte is processed per scan_valid. Back-to-back strobes on consecutive cycles are handled; no throughput limit.
- busy follows the registered state; it rises the cycle after a prefix byte.
- fifo_count updates on the same edge as the push or pop.

## Test plan
- Bytes 0x1C, F0 1C, E0 75, E0 F0 75 spaced 10 cycles apart, event_ready=1 → four events: {1C,0,0}, {1C,1,0}, {75,0,1}, {75,1,1}. No flags set.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event {E1,0,1}. busy high from after the first byte until after the eighth.
- TIMEOUT_CYCLES=16: send 0xF0, then idle 20 cycles → proto_err=1 and busy=0 at cycle 16 after the F0. Then send 0x1C → event {1C,0,0}.
- FIFO_DEPTH=4, event_ready=0: send 5 make codes 0x15,0x1D,0x24,0x2D,0x2C → fifo_count=4, overflow=1, head 0x15. Drain in order 15,1D,24,2D.
- With FIFO full, a push and event_ready=1 in the same cycle → count stays 4, no overflow. Separately, 0xFF in IDLE → rx_err=1, no event. err_clear → all flags 0.
- Assert reset in the cycle after 0xE0 → outputs 0, state IDLE. A following 0x1C yields {1C,0,0}.
